// File: rtl/counter_pkg.sv
// Shared state encoding and default widths for the sweep sequencer.
// Pure declarations: no latency, no flow control.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PASS_W = 4;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter; load wins over en. q updates one edge after the request.
// No backpressure: every request is taken on the next rising edge.
module updown_counter_core #(
  parameter int WIDTH = counter_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= up_down ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweeps the counter lo->hi->lo for a captured number of passes; start accepted in IDLE, q=lo one edge later.
// pause freezes q and state in UP/DOWN; start is ignored while a sweep or its DONE cycle is in progress.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  q,
  output logic              up_down,
  output logic              busy,
  output logic              done,
  output logic              err
);

  sweep_state_t      state;
  logic [WIDTH-1:0]  lo_r;
  logic [WIDTH-1:0]  hi_r;
  logic [PASS_W-1:0] passes_r;
  logic [PASS_W-1:0] pass_cnt;

  logic cfg_ok;
  logic last_pass;
  logic ctr_load;
  logic ctr_en;
  logic ctr_dir;

  assign cfg_ok    = (lo < hi) && (passes != '0);
  assign last_pass = (pass_cnt == passes_r - PASS_W'(1));

  // Counter direction is decided from the live q, since the turnaround step at
  // a bound happens on the same edge the registered up_down flips.
  always_comb begin
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    ctr_dir  = 1'b1;
    case (state)
      IDLE: ctr_load = start && cfg_ok;
      UP: begin
        if (!pause) begin
          ctr_en  = 1'b1;
          ctr_dir = (q != hi_r);
        end
      end
      DOWN: begin
        if (!pause) begin
          if (q != lo_r) begin
            ctr_en  = 1'b1;
            ctr_dir = 1'b0;
          end else if (!last_pass) begin
            ctr_en  = 1'b1;
            ctr_dir = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctr_en),
    .load     (ctr_load),
    .load_val (lo),
    .up_down  (ctr_dir),
    .q        (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo_r     <= '0;
      hi_r     <= '0;
      passes_r <= '0;
      pass_cnt <= '0;
      up_down  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            lo_r     <= lo;
            hi_r     <= hi;
            passes_r <= passes;
            pass_cnt <= '0;
            state    <= UP;
            busy     <= 1'b1;
            up_down  <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        UP: begin
          if (!pause && q == hi_r) begin
            state   <= DOWN;
            up_down <= 1'b0;
          end
        end
        DOWN: begin
          if (!pause && q == lo_r) begin
            up_down <= 1'b1;
            if (last_pass) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pass_cnt <= pass_cnt + PASS_W'(1);
              state    <= UP;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
